frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter FRAME_SIZE, default 4096: samples per frame before model-order adjustment.
REQ-002 Parameter CLEAR_DEPTH, default 2048: cycles oClear is held high after start-up.
REQ-003 Parameter GAP_CYCLES, default 5: idle cycles between the last sample of a frame and the next frame-done pulse.
REQ-004 Parameter SAMPLE_W, default 16: residual sample width.
REQ-005 iClock  in  1  single clock; all logic on the rising edge.
REQ-006 iReset  in  1  asynchronous, active-low reset.
REQ-007 iEnable  in  1  global advance; low freezes all state.
REQ-008 iRun  in  1  level; high requests continuous framing.
REQ-009 iM  in  4  model order for the next frame; sampled in BLIP.
REQ-010 iSampleValid  in  1  upstream sample present.
REQ-011 iSample  in  SAMPLE_W  signed upstream residual.
REQ-012 oSampleReady  out  1  upstream handshake; a sample is accepted when iSampleValid and oSampleReady are both high.
REQ-013 oFrameDone, oM[3:0], oValid, oResidual[SAMPLE_W-1:0]  out  drive Stage4 iFrameDone/iM/iValid/iResidual.
REQ-014 oClear, oS5Enable, oS4Enable  out  1 each  Stage5 RAM clear, Stage5 enable and Stage4 enable.
REQ-015 oBusy  out  1  high in any state other than IDLE; oFrameCount  out  16  number of completed frames.
REQ-016 oStallCount  out  16  stall cycles in the current frame (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, BLIP, STREAM and GAP.
REQ-018 IDLE: when iRun is high, go to CLEAR.
REQ-019 CLEAR: assert oClear and oS5Enable for exactly CLEAR_DEPTH cycles, then go to BLIP.
REQ-020 BLIP: assert oFrameDone for exactly one cycle, latch M = min(iM, 12) onto oM, reset the sample counter, then go to STREAM.
REQ-021 STREAM: assert oSampleReady; on each accept, register iSample to oResidual and pulse oValid on the next cycle (1-cycle latency).
REQ-022 STREAM: if iSampleValid is low, oValid is 0 in the following cycle and the counter holds.
REQ-023 STREAM: the accept at count FRAME_SIZE-M-1 SHALL be the last; oSampleReady drops the next cycle, the FSM enters GAP and oFrameCount increments (wraps at 65535 to 0).
REQ-024 GAP: stay for GAP_CYCLES cycles; then go to BLIP if iRun is high, else go to IDLE.
REQ-025 iRun falling during CLEAR, BLIP or STREAM SHALL NOT abort; the current frame completes.
REQ-026 oS4Enable and oS5Enable SHALL be high in every state except IDLE; in IDLE oS5Enable is low.
REQ-027 iEnable low: state, counters and oM hold; oFrameDone, oValid and oSampleReady are forced 0; a frozen BLIP emits exactly one pulse after release.
REQ-028 Re-entering CLEAR from IDLE SHALL repeat the full CLEAR_DEPTH clear.

Reset
REQ-029 On iReset low (asynchronous), the FSM goes to IDLE, all counters clear, and every output is 0, including oResidual, oM, oFrameCount and oStallCount.
REQ-030 Reset deassertion SHALL take effect on the next iClock edge; a reset mid-STREAM discards the partial frame with no oFrameDone pulse.

Configuration
REQ-031 With FRAME_SEQ_STATS_EN defined, oStallCount counts STREAM cycles with iEnable high and iSampleValid low, saturates at 65535 and clears in BLIP.
REQ-032 Without FRAME_SEQ_STATS_EN, oStallCount SHALL be constant 0 and the counter logic is not synthesized.

Structure
REQ-033 The shared package frame_seq_pkg SHALL hold the state enum, the MAX_ORDER=12 constant and the default parameter values.
REQ-034 A single sub-module, frame_seq_counter (a loadable down-counter with a terminal-count flag), SHALL be reused for the CLEAR, STREAM and GAP counts.

Verification
REQ-035 After reset, iRun=1 -> oClear high for exactly 2048 cycles, then one oFrameDone pulse, with oM=0.
REQ-036 iM=2, iSampleValid held at 1 -> exactly 4094 oValid pulses, 5 gap cycles, then the next oFrameDone; oFrameCount=1.
REQ-037 iM=15 -> oM=12 and 4084 samples are accepted.
REQ-038 10 cycles of iSampleValid=0 mid-frame -> no oValid in those cycles, the total sample count is unchanged, and oStallCount=10 with the macro (0 without it).
REQ-039 iRun dropped at sample 100 -> the frame completes, GAP runs, the FSM reaches IDLE and oBusy=0; iReset asserted mid-STREAM -> all outputs are 0 immediately.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding, the
// model-order ceiling, counter width, default parameter values and the
// model-order clipping helper.
package frame_seq_pkg;

  // Sequencer phases, in the order a frame passes through them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_BLIP   = 3'd2,
    ST_STREAM = 3'd3,
    ST_GAP    = 3'd4
  } seq_state_t;

  // Highest model order Stage4 can accept; larger requests are clipped.
  localparam int MAX_ORDER = 12;

  // Default build-time configuration.
  localparam int DEF_FRAME_SIZE  = 4096;
  localparam int DEF_CLEAR_DEPTH = 2048;
  localparam int DEF_GAP_CYCLES  = 5;
  localparam int DEF_SAMPLE_W    = 16;

  // One shared down-counter serves every phase, so it must hold the
  // largest of FRAME_SIZE-1, CLEAR_DEPTH-1 and GAP_CYCLES-1.
  localparam int CNT_W = 16;

  // Clip a requested model order to MAX_ORDER.
  function automatic logic [3:0] clip_order(input logic [3:0] m);
    return (m > 4'(MAX_ORDER)) ? 4'(MAX_ORDER) : m;
  endfunction

endpackage : frame_seq_pkg

// File: rtl/frame_sequencer_if.sv
// Sample handshake and Stage4 bus of the frame sequencer.
// slave  : the sequencer's view (accepts samples, drives Stage4).
// master : the environment's view (supplies samples, observes Stage4).
interface frame_sequencer_if
  import frame_seq_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W
) ();

  // Upstream residual handshake.
  logic                       iSampleValid;
  logic signed [SAMPLE_W-1:0] iSample;
  logic                       oSampleReady;

  // Stage4 frame interface.
  logic                       oFrameDone;
  logic [3:0]                 oM;
  logic                       oValid;
  logic signed [SAMPLE_W-1:0] oResidual;

  modport slave (
    input  iSampleValid,
    input  iSample,
    output oSampleReady,
    output oFrameDone,
    output oM,
    output oValid,
    output oResidual
  );

  modport master (
    output iSampleValid,
    output iSample,
    input  oSampleReady,
    input  oFrameDone,
    input  oM,
    input  oValid,
    input  oResidual
  );

endinterface : frame_sequencer_if

// File: rtl/frame_seq_counter.sv
// Loadable down-counter with a terminal-count flag. The sequencer loads it
// with (length - 1) on entry to a phase and the phase ends on the cycle the
// flag is high, so a load of N-1 yields a phase of exactly N counted cycles.
// Load wins over decrement; the count sticks at zero rather than wrapping.
module frame_seq_counter
  import frame_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         iClock,
  input  logic         iReset,
  input  logic         iEnable,
  input  logic         iLoad,
  input  logic [W-1:0] iLoadValue,
  input  logic         iDec,
  output logic         oTc
);

  logic [W-1:0] r_count;

  // Count register: load, decrement or hold, all frozen while iEnable is low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_count <= '0;
    end else if (iEnable) begin
      if (iLoad) begin
        r_count <= iLoadValue;
      end else if (iDec && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign oTc = (r_count == '0);

endmodule : frame_seq_counter

// File: rtl/frame_sequencer.sv
// Frame sequencer: clears the Stage5 RAM once after start-up, then frames
// the upstream residual stream for Stage4 as
//   BLIP (frame-done pulse, latch order) -> STREAM (FRAME_SIZE-M samples)
//   -> GAP (GAP_CYCLES idle) -> BLIP ... or back to IDLE when iRun is low.
// iEnable low freezes everything and masks the pulse/handshake outputs, so
// a pulse pending in a frozen cycle is delivered once enable returns.
// Optional feature macro: FRAME_SEQ_STATS_EN enables the per-frame stall
// counter on oStallCount; without it oStallCount is tied to zero.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int FRAME_SIZE  = DEF_FRAME_SIZE,
  parameter int CLEAR_DEPTH = DEF_CLEAR_DEPTH,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int SAMPLE_W    = DEF_SAMPLE_W
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iRun,
  input  logic [3:0]        iM,
  frame_sequencer_if.slave  bus,
  output logic              oClear,
  output logic              oS5Enable,
  output logic              oS4Enable,
  output logic              oBusy,
  output logic [15:0]       oFrameCount,
  output logic [15:0]       oStallCount
);

  // FSM state and registered outputs.
  seq_state_t                 r_state;
  logic                       r_clear;
  logic                       r_active;
  logic                       r_frame_done;
  logic                       r_ready;
  logic                       r_valid;
  logic [3:0]                 r_m;
  logic signed [SAMPLE_W-1:0] r_residual;
  logic [15:0]                r_frame_count;

  // Handshake and shared-counter control.
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_tc;
  logic                       w_load;
  logic                       w_dec;
  logic [CNT_W-1:0]           w_load_value;
  logic [3:0]                 w_m_next;

  assign w_m_next = clip_order(iM);
  assign w_ready  = r_ready & iEnable;
  assign w_accept = w_ready & bus.iSampleValid;

  // Shared phase counter: CLEAR length, samples left in STREAM, GAP length.
  frame_seq_counter #(
    .W (CNT_W)
  ) u_phase_cnt (
    .iClock     (iClock),
    .iReset     (iReset),
    .iEnable    (iEnable),
    .iLoad      (w_load),
    .iLoadValue (w_load_value),
    .iDec       (w_dec),
    .oTc        (w_tc)
  );

  // Counter control: load on entry to each counted phase, step while in it.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_load_value = '0;
    case (r_state)
      ST_IDLE: begin
        w_load       = iRun;
        w_load_value = CNT_W'(CLEAR_DEPTH - 1);
      end
      ST_CLEAR: begin
        w_dec = 1'b1;
      end
      ST_BLIP: begin
        // Index of the last accepted sample: FRAME_SIZE - M - 1.
        w_load       = 1'b1;
        w_load_value = CNT_W'(FRAME_SIZE - 1) - CNT_W'(w_m_next);
      end
      ST_STREAM: begin
        w_dec = w_accept;
        if (w_accept && w_tc) begin
          w_load       = 1'b1;
          w_load_value = CNT_W'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        w_dec = 1'b1;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered outputs; iRun is only consulted in IDLE
  // and at the end of GAP, so dropping it never aborts a frame in flight.
  // NOTE: r_residual is datapath, yet it is reset too because every output
  // must read zero while iReset is low.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state       <= ST_IDLE;
      r_clear       <= 1'b0;
      r_active      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_ready       <= 1'b0;
      r_valid       <= 1'b0;
      r_m           <= '0;
      r_residual    <= '0;
      r_frame_count <= '0;
    end else if (iEnable) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_residual <= bus.iSample;
      end
      case (r_state)
        ST_IDLE: begin
          if (iRun) begin
            r_state  <= ST_CLEAR;
            r_clear  <= 1'b1;
            r_active <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (w_tc) begin
            r_state      <= ST_BLIP;
            r_clear      <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        ST_BLIP: begin
          r_state      <= ST_STREAM;
          r_frame_done <= 1'b0;
          r_m          <= w_m_next;
          r_ready      <= 1'b1;
        end
        ST_STREAM: begin
          if (w_accept && w_tc) begin
            r_state       <= ST_GAP;
            r_ready       <= 1'b0;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        ST_GAP: begin
          if (w_tc) begin
            if (iRun) begin
              r_state      <= ST_BLIP;
              r_frame_done <= 1'b1;
            end else begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] r_stall_count;

  // Stall statistics: enabled STREAM cycles without a sample, saturating,
  // restarted at every frame boundary.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_stall_count <= '0;
    end else if (iEnable) begin
      if (r_state == ST_BLIP) begin
        r_stall_count <= '0;
      end else if ((r_state == ST_STREAM) && !bus.iSampleValid &&
                   (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign oStallCount = r_stall_count;
`else
  assign oStallCount = '0;
`endif

  // Pulse and handshake outputs are masked while frozen.
  assign bus.oFrameDone   = r_frame_done & iEnable;
  assign bus.oValid       = r_valid & iEnable;
  assign bus.oSampleReady = w_ready;
  assign bus.oM           = r_m;
  assign bus.oResidual    = r_residual;

  assign oClear      = r_clear;
  assign oS5Enable   = r_active;
  assign oS4Enable   = r_active;
  assign oBusy       = r_active;
  assign oFrameCount = r_frame_count;

endmodule : frame_sequencer

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer. A phase-level model (remaining clear
// cycles, samples left in the frame, gap cycles left) predicts every output
// each cycle; literal expectations pin clear length, frame lengths, order
// clipping, stall statistics, freeze behaviour, run drop and reset.
module tb_frame_sequencer;

  localparam int FS = 4096;
  localparam int CD = 2048;
  localparam int GC = 5;
  localparam int SW = 16;

  typedef enum int {P_IDLE, P_CLEAR, P_BLIP, P_STREAM, P_GAP} phase_t;
  typedef enum int {EV_FD, EV_FC, EV_IDLE} event_t;

  typedef struct packed {
    logic        fd;
    logic [3:0]  m;
    logic        valid;
    logic [15:0] res;
    logic        ready;
    logic        clear;
    logic        s5;
    logic        s4;
    logic        busy;
    logic [15:0] fc;
    logic [15:0] stall;
  } out_t;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iEnable;
  logic        iRun;
  logic [3:0]  iM;
  logic        oClear;
  logic        oS5Enable;
  logic        oS4Enable;
  logic        oBusy;
  logic [15:0] oFrameCount;
  logic [15:0] oStallCount;

  frame_sequencer_if #(.SAMPLE_W(SW)) bus ();

  frame_sequencer #(
    .FRAME_SIZE  (FS),
    .CLEAR_DEPTH (CD),
    .GAP_CYCLES  (GC),
    .SAMPLE_W    (SW)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iEnable     (iEnable),
    .iRun        (iRun),
    .iM          (iM),
    .bus         (bus),
    .oClear      (oClear),
    .oS5Enable   (oS5Enable),
    .oS4Enable   (oS4Enable),
    .oBusy       (oBusy),
    .oFrameCount (oFrameCount),
    .oStallCount (oStallCount)
  );

  always #5 iClock = ~iClock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Monitors accumulated from DUT outputs at every sample point.
  int   cnt_clear = 0, cnt_valid = 0, cnt_accept = 0, cnt_fd = 0;
  int   last_accept_cyc = 0, fd_cyc = 0;
  out_t last_act;
  logic [15:0] pat = 16'h1234;

  // Model state.
  phase_t      mp = P_IDLE;
  int          m_left = 0;
  int          m_samples = 0;
  logic [3:0]  m_m = '0;
  logic [15:0] m_fc = '0;
  logic [15:0] m_stall = '0;
  logic        m_vpend = 1'b0;
  logic [15:0] m_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic out_t get_act();
    out_t a;
    a.fd    = bus.oFrameDone;
    a.m     = bus.oM;
    a.valid = bus.oValid;
    a.res   = bus.oResidual;
    a.ready = bus.oSampleReady;
    a.clear = oClear;
    a.s5    = oS5Enable;
    a.s4    = oS4Enable;
    a.busy  = oBusy;
    a.fc    = oFrameCount;
    a.stall = oStallCount;
    return a;
  endfunction

  // Sample at the falling edge: compare against the model, update monitors,
  // then advance the model with the inputs the next rising edge will see.
  task automatic model_step();
    out_t a_out;
    out_t e_out;
    logic acc;
    @(negedge iClock);
    cyc++;
    if (!iReset) begin
      mp = P_IDLE; m_left = 0; m_samples = 0; m_m = '0;
      m_fc = '0; m_stall = '0; m_vpend = 1'b0; m_res = '0;
    end
    a_out       = get_act();
    e_out       = '0;
    e_out.fd    = (mp == P_BLIP) && iEnable;
    e_out.m     = m_m;
    e_out.valid = m_vpend && iEnable;
    e_out.res   = m_res;
    e_out.ready = (mp == P_STREAM) && iEnable;
    e_out.clear = (mp == P_CLEAR);
    e_out.s5    = (mp != P_IDLE);
    e_out.s4    = (mp != P_IDLE);
    e_out.busy  = (mp != P_IDLE);
    e_out.fc    = m_fc;
    e_out.stall = m_stall;
    check("cycle_outputs", 64'(a_out), 64'(e_out));
    last_act = a_out;

    cnt_clear += int'(a_out.clear);
    cnt_valid += int'(a_out.valid);
    cnt_fd    += int'(a_out.fd);
    if (a_out.fd) fd_cyc = cyc;
    if (a_out.ready && bus.iSampleValid) begin
      cnt_accept++;
      last_accept_cyc = cyc;
    end

    if (iReset && iEnable) begin
      acc     = e_out.ready && bus.iSampleValid;
      m_vpend = acc;
      if (acc) m_res = bus.iSample;
      case (mp)
        P_IDLE: if (iRun) begin mp = P_CLEAR; m_left = CD; end
        P_CLEAR: begin
          m_left--;
          if (m_left == 0) mp = P_BLIP;
        end
        P_BLIP: begin
          m_m       = (iM > 4'd12) ? 4'd12 : iM;
          m_samples = FS - int'(m_m);
          m_stall   = '0;
          mp        = P_STREAM;
        end
        P_STREAM: begin
          if (bus.iSampleValid) begin
            m_samples--;
            if (m_samples == 0) begin
              mp = P_GAP; m_left = GC; m_fc = m_fc + 16'd1;
            end
          end else begin
`ifdef FRAME_SEQ_STATS_EN
            if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
          end
        end
        P_GAP: begin
          m_left--;
          if (m_left == 0) mp = iRun ? P_BLIP : P_IDLE;
        end
        default: mp = P_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge iClock);
    #1;
    pat = pat * 16'd5 + 16'd1;
    bus.iSample = pat;
  endtask

  task automatic wait_ev(input event_t ev, input int budget, input string name);
    bit seen = 1'b0;
    logic [15:0] fc0 = last_act.fc;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      case (ev)
        EV_FD:   seen = last_act.fd;
        EV_FC:   seen = (last_act.fc != fc0);
        default: seen = !last_act.busy;
      endcase
    end
    check({name, "_reached"}, 64'(seen), 64'(1));
  endtask

  int c0, v0, a0, f0, r0;

  initial begin
    iReset = 1'b0; iEnable = 1'b1; iRun = 1'b0; iM = 4'd0;
    bus.iSampleValid = 1'b0; bus.iSample = '0;

    // Reset state.
    repeat (3) tick();
    check("reset_outputs", 64'(last_act), 64'(0));

    // Start-up clear then first frame-done with the reset order.
    iReset = 1'b1; iRun = 1'b1; iM = 4'd2; bus.iSampleValid = 1'b1;
    c0 = cnt_clear;
    wait_ev(EV_FD, 3000, "first_fd");
    check("clear_len", 64'(cnt_clear - c0), 64'(CD));
    check("first_fd_m", 64'(last_act.m), 64'(0));

    // Frame with M=2 and continuous samples; next frame requests M=15.
    v0 = cnt_valid;
    iM = 4'd15;
    wait_ev(EV_FD, 5000, "second_fd");
    check("frame1_valid", 64'(cnt_valid - v0), 64'(4094));
    check("frame1_count", 64'(last_act.fc), 64'(1));
    check("gap_len", 64'(fd_cyc - last_accept_cyc - 1), 64'(GC));

    // M clipped to 12; a 10-cycle stall window mid-frame.
    a0 = cnt_accept;
    tick();
    check("clip_m", 64'(last_act.m), 64'(12));
    repeat (199) tick();
    bus.iSampleValid = 1'b0;
    tick();
    v0 = cnt_valid;
    repeat (9) tick();
    bus.iSampleValid = 1'b1;
    tick();
    check("stall_no_valid", 64'(cnt_valid - v0), 64'(0));
`ifdef FRAME_SEQ_STATS_EN
    check("stall_count", 64'(last_act.stall), 64'(10));
`else
    check("stall_count", 64'(last_act.stall), 64'(0));
`endif

    // Freeze mid-stream: handshake and valid masked, nothing accepted.
    repeat (50) tick();
    iEnable = 1'b0;
    r0 = cnt_accept; v0 = cnt_valid;
    repeat (3) tick();
    check("freeze_accepts", 64'(cnt_accept - r0), 64'(0));
    check("freeze_valid", 64'(cnt_valid - v0), 64'(0));
    check("freeze_ready", 64'(last_act.ready), 64'(0));
    iEnable = 1'b1; iM = 4'd5;
    wait_ev(EV_FC, 5000, "frame2_end");
    check("frame2_accepts", 64'(cnt_accept - a0), 64'(4084));

    // Freeze while sitting in BLIP: exactly one pulse after release.
    repeat (4) tick();
    iEnable = 1'b0;
    f0 = cnt_fd; a0 = cnt_accept;
    repeat (3) tick();
    iEnable = 1'b1;
    repeat (3) tick();
    check("frozen_blip_pulses", 64'(cnt_fd - f0), 64'(1));
    check("frame3_m", 64'(last_act.m), 64'(5));

    // Drop iRun around sample 100: frame completes, GAP, then IDLE.
    repeat (97) tick();
    iRun = 1'b0;
    wait_ev(EV_IDLE, 6000, "run_drop_idle");
    check("frame3_accepts", 64'(cnt_accept - a0), 64'(4091));
    check("run_drop_gap", 64'(cyc - last_accept_cyc), 64'(GC + 1));
    check("run_drop_count", 64'(last_act.fc), 64'(3));
    check("run_drop_s5", 64'(last_act.s5), 64'(0));
    repeat (5) tick();
    check("idle_stays", 64'(last_act.busy), 64'(0));

    // Re-entering from IDLE repeats the full clear.
    iRun = 1'b1; iM = 4'd3;
    c0 = cnt_clear;
    wait_ev(EV_FD, 3000, "reclear_fd");
    check("reclear_len", 64'(cnt_clear - c0), 64'(CD));

    // Reset mid-stream: outputs clear at once, no pulse afterwards.
    repeat (50) tick();
    iReset = 1'b0;
    #1;
    check("rst_mid_outputs", 64'(get_act()), 64'(0));
    f0 = cnt_fd;
    repeat (3) tick();
    iReset = 1'b1; iRun = 1'b0;
    repeat (20) tick();
    check("post_rst_no_fd", 64'(cnt_fd - f0), 64'(0));
    check("post_rst_idle", 64'(last_act), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_frame_sequencer
